// File: rtl/jtag_seq_pkg.sv
// Shared types and constants for the JTAG scan sequencer.
// Contents:
//   state_t        sequencer FSM states
//   OP_*           cmd_op encodings
//   TMS_*          TMS sequences, LSB = first TCK cycle of the state
package jtag_seq_pkg;

    typedef enum logic [2:0] {
        INIT_RST,
        IDLE,
        PRE_DR,
        PRE_IR,
        SHIFT,
        POST,
        TRST_SEQ,
        RSP
    } state_t;

    localparam logic [1:0] OP_DR    = 2'd0;
    localparam logic [1:0] OP_IR    = 2'd1;
    localparam logic [1:0] OP_RESET = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    // Run-Test/Idle -> Select-DR -> Capture-DR -> Shift-DR
    localparam logic [2:0] TMS_PRE_DR    = 3'b001;
    // Run-Test/Idle -> Select-DR -> Select-IR -> Capture-IR -> Shift-IR
    localparam logic [3:0] TMS_PRE_IR    = 4'b0011;
    // Exit1 -> Update -> Run-Test/Idle
    localparam logic [1:0] TMS_POST      = 2'b01;
    // Five ones reach Test-Logic-Reset from any state, the zero parks in Run-Test/Idle
    localparam logic [5:0] TMS_TAP_RESET = 6'b011111;

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider. While enabled, TCK toggles every CLK_DIV clocks; disabled, it
// rests at 0 with the counter reloaded so the first rise comes CLK_DIV clocks
// after enable goes high.
// Ports:
//   clock, reset  system clock, async active-high reset
//   enable        run the divider
//   tck_rise      strobe: this clock edge drives TCK 0->1
//   tck_fall      strobe: this clock edge drives TCK 1->0
//   tck           registered TCK level
module jtag_tck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic tck_rise,
    output logic tck_fall,
    output logic tck
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          term;

    assign term     = enable && (cnt == '0);
    assign tck_rise = term && !tck;
    assign tck_fall = term && tck;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= RELOAD;
            tck <= 1'b0;
        end else if (!enable) begin
            cnt <= RELOAD;
            tck <= 1'b0;
        end else if (cnt == '0) begin
            cnt <= RELOAD;
            tck <= ~tck;
        end else begin
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/jtag_scan_sequencer.sv
// JTAG host controller: takes IR/DR scan and TAP reset commands, walks the
// 1149.1 TAP, drives TCK/TMS/TDI/TRSTn and returns captured TDO.
// Ports:
//   clock, reset              system clock, async active-high reset
//   cmd_valid/ready/op/len/data   command channel (data shifted LSB first)
//   rsp_valid/ready/data/undriven response channel
//   busy                      high in every state except IDLE
//   jtag_TCK/TMS/TDI/TRSTn    registered JTAG outputs
//   jtag_TDO_data/driven      TDO from the target and its drive flag
//
// state    | meaning
// INIT_RST | post-reset TMS 1,1,1,1,1,0 to Run-Test/Idle, no response
// IDLE     | cmd_ready=1, waiting for a command
// PRE_DR   | TMS 1,0,0 into Shift-DR
// PRE_IR   | TMS 1,1,0,0 into Shift-IR
// SHIFT    | len cycles of TDI out / TDO in, TMS=1 on the last
// POST     | TMS 1,0 through Update back to Run-Test/Idle
// TRST_SEQ | TAP reset command, same TMS pattern as INIT_RST
// RSP      | rsp_valid held until rsp_ready
module jtag_scan_sequencer
    import jtag_seq_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int MAX_BITS = 64,
    parameter int LEN_W    = 7
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic [MAX_BITS-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [MAX_BITS-1:0] rsp_data,
    output logic                rsp_undriven,
    output logic                busy,
    output logic                jtag_TCK,
    output logic                jtag_TMS,
    output logic                jtag_TDI,
    output logic                jtag_TRSTn,
    input  logic                jtag_TDO_data,
    input  logic                jtag_TDO_driven
);

    localparam int CNT_W = ($clog2(MAX_BITS) < 3) ? 3 : $clog2(MAX_BITS);

    state_t              state;
    logic                tck_en;
    logic                tck_rise;
    logic                tck_fall;
    logic [5:0]          seq_q;      // TMS values still to present in this state
    logic [CNT_W-1:0]    cnt_q;      // TCK cycles left in this state after the current one
    logic [CNT_W-1:0]    len_last;
    logic [CNT_W-1:0]    len_last_q;
    logic [MAX_BITS-1:0] data_q;     // shifts right so data_q[0] is the current TDI bit
    logic [MAX_BITS-1:0] mask_q;     // one-hot position of the current shift bit

    assign tck_en = (state != IDLE) && (state != RSP);

    jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
        .clock    (clock),
        .reset    (reset),
        .enable   (tck_en),
        .tck_rise (tck_rise),
        .tck_fall (tck_fall),
        .tck      (jtag_TCK)
    );

    // Length 0 behaves as 1, anything above MAX_BITS is clamped; stored as len-1.
    always_comb begin
        len_last = '0;
        if (int'(cmd_len) > MAX_BITS)
            len_last = CNT_W'(MAX_BITS - 1);
        else if (cmd_len != '0)
            len_last = CNT_W'(int'(cmd_len) - 1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= INIT_RST;
            jtag_TMS     <= 1'b1;
            jtag_TDI     <= 1'b0;
            jtag_TRSTn   <= 1'b0;
            cmd_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_undriven <= 1'b0;
            busy         <= 1'b1;
            seq_q        <= 6'(TMS_TAP_RESET >> 1);
            cnt_q        <= CNT_W'(5);
            len_last_q   <= '0;
            data_q       <= '0;
            mask_q       <= '0;
        end else begin
            jtag_TRSTn <= 1'b1;
            case (state)
                INIT_RST, TRST_SEQ, PRE_DR, PRE_IR, POST: begin
                    if (tck_fall) begin
                        if (cnt_q != '0) begin
                            jtag_TMS <= seq_q[0];
                            seq_q    <= seq_q >> 1;
                            cnt_q    <= cnt_q - CNT_W'(1);
                        end else begin
                            case (state)
                                INIT_RST: begin
                                    state     <= IDLE;
                                    busy      <= 1'b0;
                                    cmd_ready <= 1'b1;
                                end
                                PRE_DR, PRE_IR: begin
                                    state    <= SHIFT;
                                    jtag_TMS <= (len_last_q == '0);
                                    jtag_TDI <= data_q[0];
                                    cnt_q    <= len_last_q;
                                    mask_q   <= MAX_BITS'(1);
                                end
                                POST, TRST_SEQ: begin
                                    state     <= RSP;
                                    rsp_valid <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready    <= 1'b0;
                        busy         <= 1'b1;
                        len_last_q   <= len_last;
                        data_q       <= cmd_data;
                        rsp_data     <= '0;
                        rsp_undriven <= 1'b0;
                        jtag_TDI     <= 1'b0;
                        case (cmd_op)
                            OP_DR: begin
                                state    <= PRE_DR;
                                jtag_TMS <= TMS_PRE_DR[0];
                                seq_q    <= 6'(TMS_PRE_DR >> 1);
                                cnt_q    <= CNT_W'(2);
                            end
                            OP_IR: begin
                                state    <= PRE_IR;
                                jtag_TMS <= TMS_PRE_IR[0];
                                seq_q    <= 6'(TMS_PRE_IR >> 1);
                                cnt_q    <= CNT_W'(3);
                            end
                            OP_RESET, OP_RSVD: begin
                                state    <= TRST_SEQ;
                                jtag_TMS <= TMS_TAP_RESET[0];
                                seq_q    <= 6'(TMS_TAP_RESET >> 1);
                                cnt_q    <= CNT_W'(5);
                            end
                        endcase
                    end
                end
                SHIFT: begin
                    // An undriven TDO leaves the bit at 0 and flags the command.
                    if (tck_rise) begin
                        if (!jtag_TDO_driven)
                            rsp_undriven <= 1'b1;
                        else if (jtag_TDO_data)
                            rsp_data <= rsp_data | mask_q;
                    end
                    if (tck_fall) begin
                        if (cnt_q != '0) begin
                            jtag_TMS <= (cnt_q == CNT_W'(1));
                            jtag_TDI <= data_q[1];
                            data_q   <= data_q >> 1;
                            mask_q   <= mask_q << 1;
                            cnt_q    <= cnt_q - CNT_W'(1);
                        end else begin
                            state    <= POST;
                            jtag_TMS <= TMS_POST[0];
                            jtag_TDI <= 1'b0;
                            seq_q    <= 6'(TMS_POST >> 1);
                            cnt_q    <= CNT_W'(1);
                        end
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// Directed bench for jtag_scan_sequencer with a behavioural TAP (BYPASS for
// DR, 5-bit IR capturing 00001) attached to the JTAG pins.
module tb_jtag_scan_sequencer;

    localparam int CLK_DIV  = 2;
    localparam int MAX_BITS = 64;
    localparam int LEN_W    = 7;

    localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5,
                   PAUDR = 6, EX2DR = 7, UPDDR = 8, SELIR = 9, CAPIR = 10,
                   SHIR = 11, EX1IR = 12, PAUIR = 13, EX2IR = 14, UPDIR = 15;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                cmd_valid = 1'b0;
    logic                cmd_ready;
    logic [1:0]          cmd_op = '0;
    logic [LEN_W-1:0]    cmd_len = '0;
    logic [MAX_BITS-1:0] cmd_data = '0;
    logic                rsp_valid;
    logic                rsp_ready = 1'b0;
    logic [MAX_BITS-1:0] rsp_data;
    logic                rsp_undriven;
    logic                busy;
    logic                jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn;
    logic                jtag_TDO_data;
    logic                jtag_TDO_driven = 1'b1;

    int   compared = 0;
    int   mismatched = 0;
    int   tap_state = TLR;
    logic bypass = 1'b0;
    logic [4:0] ir_sr = 5'b00001;
    int   tck_cnt = 0;
    int   rsp_rises = 0;
    logic tms_log [4096];
    logic tdi_log [4096];

    always #5 clock = ~clock;

    jtag_scan_sequencer #(.CLK_DIV(CLK_DIV), .MAX_BITS(MAX_BITS), .LEN_W(LEN_W)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_undriven(rsp_undriven), .busy(busy),
        .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS), .jtag_TDI(jtag_TDI),
        .jtag_TRSTn(jtag_TRSTn), .jtag_TDO_data(jtag_TDO_data),
        .jtag_TDO_driven(jtag_TDO_driven)
    );

    function automatic int next_tap(input int s, input logic tms);
        case (s)
            TLR:   return tms ? TLR   : RTI;
            RTI:   return tms ? SELDR : RTI;
            SELDR: return tms ? SELIR : CAPDR;
            CAPDR: return tms ? EX1DR : SHDR;
            SHDR:  return tms ? EX1DR : SHDR;
            EX1DR: return tms ? UPDDR : PAUDR;
            PAUDR: return tms ? EX2DR : PAUDR;
            EX2DR: return tms ? UPDDR : SHDR;
            UPDDR: return tms ? SELDR : RTI;
            SELIR: return tms ? TLR   : CAPIR;
            CAPIR: return tms ? EX1IR : SHIR;
            SHIR:  return tms ? EX1IR : SHIR;
            EX1IR: return tms ? UPDIR : PAUIR;
            PAUIR: return tms ? EX2IR : PAUIR;
            EX2IR: return tms ? UPDIR : SHIR;
            default: return tms ? SELDR : RTI;
        endcase
    endfunction

    assign jtag_TDO_data = (tap_state == SHIR) ? ir_sr[0] : bypass;

    always @(posedge jtag_TCK or negedge jtag_TRSTn) begin
        if (!jtag_TRSTn) begin
            tap_state <= TLR;
        end else begin
            case (tap_state)
                CAPDR:   bypass <= 1'b0;
                SHDR:    bypass <= jtag_TDI;
                CAPIR:   ir_sr  <= 5'b00001;
                SHIR:    ir_sr  <= {jtag_TDI, ir_sr[4:1]};
                default: ;
            endcase
            tap_state <= next_tap(tap_state, jtag_TMS);
        end
    end

    always @(posedge jtag_TCK) begin
        if (tck_cnt < 4096) begin
            tms_log[tck_cnt] <= jtag_TMS;
            tdi_log[tck_cnt] <= jtag_TDI;
        end
        tck_cnt <= tck_cnt + 1;
    end

    always @(posedge rsp_valid) rsp_rises <= rsp_rises + 1;

    function automatic logic [127:0] log_bits(input int base, input int n, input bit use_tdi);
        logic [127:0] v = '0;
        for (int i = 0; i < n && i < 128; i++)
            if (base + i < 4096)
                v[i] = use_tdi ? tdi_log[base + i] : tms_log[base + i];
        return v;
    endfunction

    task automatic wait_ready(input string name);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 2000) begin @(posedge clock); #1; n++; end
        compared++;
        if (cmd_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL %s_ready_timeout: cmd_ready got %b want 1", name, cmd_ready);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [LEN_W-1:0] len,
                         input logic [MAX_BITS-1:0] data, input string name);
        cmd_op = op; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
        wait_ready(name);
        @(posedge clock); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name, output logic [MAX_BITS-1:0] d, output logic u);
        int n = 0;
        while (rsp_valid !== 1'b1 && n < 2000) begin @(posedge clock); #1; n++; end
        compared++;
        if (rsp_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL %s_rsp_timeout: rsp_valid got %b want 1", name, rsp_valid);
        end
        d = rsp_data; u = rsp_undriven;
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        int base, r0;
        repeat (3) @(posedge clock);
        #1;
        compared++;
        if ({jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn} !== 4'b0100) begin
            mismatched++;
            $display("FAIL reset_jtag_pins: got %b want 0100", {jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn});
        end
        compared++;
        if ({cmd_ready, rsp_valid, rsp_undriven, busy} !== 4'b0001 || rsp_data !== '0) begin
            mismatched++;
            $display("FAIL reset_ctrl: got rdy/vld/und/busy %b data %h want 0001 data 0",
                     {cmd_ready, rsp_valid, rsp_undriven, busy}, rsp_data);
        end
        base = tck_cnt; r0 = rsp_rises;
        @(negedge clock); reset = 1'b0;
        @(posedge clock); #1;
        compared++;
        if (jtag_TRSTn !== 1'b1) begin
            mismatched++; $display("FAIL reset_trstn_release: got %b want 1", jtag_TRSTn);
        end
        wait_ready("init");
        compared++;
        if (tck_cnt - base !== 6) begin
            mismatched++; $display("FAIL init_pulses: got %0d want 6", tck_cnt - base);
        end
        compared++;
        if (log_bits(base, 6, 0) !== 128'h1F) begin
            mismatched++; $display("FAIL init_tms: got %h want 1f", log_bits(base, 6, 0));
        end
        compared++;
        if (tap_state !== RTI || busy !== 1'b0 || rsp_rises !== r0) begin
            mismatched++;
            $display("FAIL init_end: tap %0d busy %b rsp_rises %0d want tap 1 busy 0 rsp_rises %0d",
                     tap_state, busy, rsp_rises, r0);
        end
    endtask

    task automatic test_dr_bypass();
        int base;
        logic [MAX_BITS-1:0] d;
        logic u;
        jtag_TDO_driven = 1'b1;
        base = tck_cnt;
        issue(2'd0, 7'd8, 64'hA5, "dr8");
        wait_rsp("dr8", d, u);
        compared++;
        if (tck_cnt - base !== 13) begin
            mismatched++; $display("FAIL dr8_pulses: got %0d want 13", tck_cnt - base);
        end
        compared++;
        if (log_bits(base, 13, 0) !== 128'h0C01) begin
            mismatched++; $display("FAIL dr8_tms: got %h want c01", log_bits(base, 13, 0));
        end
        compared++;
        if (log_bits(base, 13, 1) !== 128'h0528) begin
            mismatched++; $display("FAIL dr8_tdi: got %h want 528", log_bits(base, 13, 1));
        end
        compared++;
        if (d !== 64'h4A || u !== 1'b0) begin
            mismatched++; $display("FAIL dr8_rsp: got %h und %b want 4a und 0", d, u);
        end
        compared++;
        if (tap_state !== RTI) begin
            mismatched++; $display("FAIL dr8_tap_end: got %0d want 1", tap_state);
        end
    endtask

    task automatic test_tap_reset();
        int base;
        logic [MAX_BITS-1:0] d;
        logic u;
        for (int k = 2; k <= 3; k++) begin
            base = tck_cnt;
            issue(2'(k), 7'd8, '1, "trst");
            wait_rsp("trst", d, u);
            compared++;
            if (tck_cnt - base !== 6 || log_bits(base, 6, 0) !== 128'h1F) begin
                mismatched++;
                $display("FAIL trst_op%0d_tms: pulses %0d tms %h want 6 and 1f", k, tck_cnt - base, log_bits(base, 6, 0));
            end
            compared++;
            if (d !== '0 || u !== 1'b0 || tap_state !== RTI) begin
                mismatched++;
                $display("FAIL trst_op%0d_rsp: data %h und %b tap %0d want 0 0 1", k, d, u, tap_state);
            end
        end
    endtask

    task automatic test_ir_scan();
        int base, n, run, hi_runs, bad_runs;
        logic prev, seen_hi;
        logic [MAX_BITS-1:0] d;
        logic u;
        base = tck_cnt;
        issue(2'd1, 7'd5, 64'h01, "ir5");
        n = 0; run = 0; hi_runs = 0; bad_runs = 0; prev = jtag_TCK; seen_hi = 1'b0;
        while (rsp_valid !== 1'b1 && n < 2000) begin
            @(posedge clock); #1; n++;
            run++;
            if (jtag_TCK !== prev) begin
                if (prev) begin hi_runs++; seen_hi = 1'b1; if (run != CLK_DIV) bad_runs++; end
                else if (seen_hi && run != CLK_DIV) bad_runs++;
                run = 0;
                prev = jtag_TCK;
            end
        end
        wait_rsp("ir5", d, u);
        compared++;
        if (tck_cnt - base !== 11 || hi_runs !== 11) begin
            mismatched++; $display("FAIL ir5_pulses: got %0d/%0d want 11", tck_cnt - base, hi_runs);
        end
        compared++;
        if (bad_runs !== 0) begin
            mismatched++; $display("FAIL ir5_tck_phase: bad phases %0d want 0", bad_runs);
        end
        compared++;
        if (log_bits(base, 11, 0) !== 128'h303) begin
            mismatched++; $display("FAIL ir5_tms: got %h want 303", log_bits(base, 11, 0));
        end
        compared++;
        if (log_bits(base, 11, 1) !== 128'h010) begin
            mismatched++; $display("FAIL ir5_tdi: got %h want 010", log_bits(base, 11, 1));
        end
        compared++;
        if (d !== 64'h01 || u !== 1'b0 || tap_state !== RTI) begin
            mismatched++; $display("FAIL ir5_rsp: data %h und %b tap %0d want 1 0 1", d, u, tap_state);
        end
    endtask

    task automatic test_len_bounds();
        int base;
        logic [MAX_BITS-1:0] d;
        logic u;
        jtag_TDO_driven = 1'b0;
        base = tck_cnt;
        issue(2'd0, 7'd0, '1, "len0");
        wait_rsp("len0", d, u);
        compared++;
        if (tck_cnt - base !== 6 || log_bits(base, 6, 0) !== 128'h19 || log_bits(base, 6, 1) !== 128'h08) begin
            mismatched++;
            $display("FAIL len0_seq: pulses %0d tms %h tdi %h want 6 19 08",
                     tck_cnt - base, log_bits(base, 6, 0), log_bits(base, 6, 1));
        end
        compared++;
        if (d !== '0 || u !== 1'b1) begin
            mismatched++; $display("FAIL len0_rsp: data %h und %b want 0 1", d, u);
        end
        base = tck_cnt;
        issue(2'd0, 7'd100, '1, "len100");
        wait_rsp("len100", d, u);
        compared++;
        if (tck_cnt - base !== 69 || log_bits(base + 3, 64, 1) !== {64'h0, 64'hFFFF_FFFF_FFFF_FFFF}) begin
            mismatched++;
            $display("FAIL len100_shift: pulses %0d tdi %h want 69 and 64 ones", tck_cnt - base, log_bits(base + 3, 64, 1));
        end
        compared++;
        if (d !== '0 || u !== 1'b1 || tap_state !== RTI) begin
            mismatched++; $display("FAIL len100_rsp: data %h und %b tap %0d want 0 1 1", d, u, tap_state);
        end
        jtag_TDO_driven = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [MAX_BITS-1:0] d0, d1;
        logic u1;
        int base, n, bad_valid, bad_data, bad_ready, bad_tck;
        bad_valid = 0; bad_data = 0; bad_ready = 0; bad_tck = 0;
        issue(2'd0, 7'd4, 64'h0F, "hold");
        n = 0;
        while (rsp_valid !== 1'b1 && n < 2000) begin @(posedge clock); #1; n++; end
        compared++;
        if (rsp_valid !== 1'b1) begin
            mismatched++; $display("FAIL hold_rsp_timeout: rsp_valid got %b want 1", rsp_valid);
        end
        d0 = rsp_data; base = tck_cnt;
        cmd_op = 2'd1; cmd_len = 7'd8; cmd_data = '1;
        for (int i = 0; i < 20; i++) begin
            cmd_valid = ~cmd_valid;
            @(posedge clock); #1;
            if (rsp_valid !== 1'b1) bad_valid++;
            if (rsp_data !== d0) bad_data++;
            if (cmd_ready !== 1'b0 || busy !== 1'b1) bad_ready++;
            if (jtag_TCK !== 1'b0) bad_tck++;
        end
        compared++;
        if (d0 !== 64'hE) begin
            mismatched++; $display("FAIL hold_data: got %h want e", d0);
        end
        compared++;
        if (bad_valid !== 0 || bad_data !== 0) begin
            mismatched++; $display("FAIL hold_stable: valid drops %0d data changes %0d want 0 0", bad_valid, bad_data);
        end
        compared++;
        if (bad_ready !== 0 || bad_tck !== 0 || tck_cnt !== base) begin
            mismatched++;
            $display("FAIL hold_quiet: ready/busy errs %0d tck errs %0d pulses %0d want 0 0 0", bad_ready, bad_tck, tck_cnt - base);
        end
        cmd_op = 2'd0; cmd_len = 7'd4; cmd_data = 64'h5; cmd_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        compared++;
        if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin
            mismatched++; $display("FAIL b2b_release: vld/rdy/busy got %b want 010", {rsp_valid, cmd_ready, busy});
        end
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        compared++;
        if ({cmd_ready, busy} !== 2'b01) begin
            mismatched++; $display("FAIL b2b_accept: rdy/busy got %b want 01", {cmd_ready, busy});
        end
        wait_rsp("b2b", d1, u1);
        compared++;
        if (d1 !== 64'hA || u1 !== 1'b0) begin
            mismatched++; $display("FAIL b2b_rsp: data %h und %b want a 0", d1, u1);
        end
    endtask

    task automatic test_abort();
        int base, n, r0;
        base = tck_cnt;
        issue(2'd0, 7'd32, 64'hDEAD_BEEF, "abort");
        n = 0;
        while (tck_cnt - base < 7 && n < 2000) begin @(posedge clock); #1; n++; end
        compared++;
        if (tck_cnt - base !== 7 || jtag_TCK !== 1'b1 || rsp_data !== 64'hE) begin
            mismatched++;
            $display("FAIL abort_setup: pulses %0d tck %b data %h want 7 1 e", tck_cnt - base, jtag_TCK, rsp_data);
        end
        r0 = rsp_rises;
        @(negedge clock); reset = 1'b1;
        #1;
        compared++;
        if ({jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn} !== 4'b0100) begin
            mismatched++;
            $display("FAIL abort_pins: got %b want 0100", {jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn});
        end
        compared++;
        if ({cmd_ready, rsp_valid, rsp_undriven, busy} !== 4'b0001 || rsp_data !== '0 || tap_state !== TLR) begin
            mismatched++;
            $display("FAIL abort_ctrl: rdy/vld/und/busy %b data %h tap %0d want 0001 0 0",
                     {cmd_ready, rsp_valid, rsp_undriven, busy}, rsp_data, tap_state);
        end
        repeat (3) @(posedge clock);
        base = tck_cnt;
        @(negedge clock); reset = 1'b0;
        wait_ready("abort_init");
        repeat (10) @(posedge clock);
        #1;
        compared++;
        if (tck_cnt - base !== 6 || log_bits(base, 6, 0) !== 128'h1F || tap_state !== RTI) begin
            mismatched++;
            $display("FAIL abort_replay: pulses %0d tms %h tap %0d want 6 1f 1", tck_cnt - base, log_bits(base, 6, 0), tap_state);
        end
        compared++;
        if (rsp_rises !== r0 || rsp_valid !== 1'b0) begin
            mismatched++; $display("FAIL abort_no_rsp: rsp_rises %0d valid %b want %0d 0", rsp_rises, rsp_valid, r0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_dr_bypass();
        test_tap_reset();
        test_ir_scan();
        test_len_bounds();
        test_back_to_back();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/jtag_scan_sequencer.md
Name: jtag_scan_sequencer

Overview:
Synthesizable JTAG host controller. It accepts scan commands (IR scan, DR scan, TAP reset) on a valid/ready interface, walks the IEEE 1149.1 TAP state machine, and drives TCK/TMS/TDI/TRSTn. It captures TDO and returns each result on a valid/ready response channel. It sits between a debug-transport front end and the DUT's jtag_* pins, in place of a host-driven bit-banger.

Parameters:
CLK_DIV, 4, TCK half-period in clock cycles (>=1); one TCK period = 2*CLK_DIV clocks
MAX_BITS, 64, maximum scan length and data width
LEN_W, 7, width of cmd_len

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command valid
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
cmd_op  input  2  0=DR scan, 1=IR scan, 2=TAP reset, 3=reserved (treated as TAP reset)
cmd_len  input  LEN_W  scan length in bits
cmd_data  input  MAX_BITS  TDI data, LSB shifted first
rsp_valid  output  1  response valid
rsp_ready  input  1  response accepted when rsp_valid && rsp_ready
rsp_data  output  MAX_BITS  captured TDO; bit i = i-th shifted bit; bits >= len are 0
rsp_undriven  output  1  at least one sampled TDO bit had jtag_TDO_driven=0
busy  output  1  1 in every state except IDLE
jtag_TCK  output  1  test clock
jtag_TMS  output  1  test mode select
jtag_TDI  output  1  test data in
jtag_TRSTn  output  1  TAP reset, active low
jtag_TDO_data  input  1  TDO from DUT
jtag_TDO_driven  input  1  DUT is driving TDO

Behaviour:
- Reset values (async): jtag_TCK=0, jtag_TMS=1, jtag_TDI=0, jtag_TRSTn=0, cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_undriven=0, busy=1, state=INIT_RST.
- jtag_TRSTn is a register. It goes to 1 on the first clock edge after reset deasserts and stays 1.
- TCK timing: the divider emits a fall strobe and a rise strobe, each CLK_DIV clocks apart.
  - All outputs are registered.
  - TMS and TDI update on the same clock edge that drives TCK 1->0.
  - TDO is sampled on the clock edge that drives TCK 0->1, using the input values present before that edge.
  - The divider runs only when state != IDLE/RSP. TCK rests at 0.
- Length rule: cmd_len=0 is treated as 1; cmd_len>MAX_BITS is clamped to MAX_BITS. The length is latched at acceptance.
- States, with the TMS value presented per TCK cycle:
  - INIT_RST: TMS 1,1,1,1,1,0 (6 TCK cycles). Ends in Run-Test/Idle. Next state IDLE; no response is generated.
  - IDLE: cmd_ready=1. On accept, latch op/len/data and clear the capture register and the undriven flag. Next state: DR->PRE_DR, IR->PRE_IR, reset->TRST_SEQ.
  - PRE_DR: TMS 1,0,0 (Select-DR, Capture-DR, Shift-DR). TDI=0.
  - PRE_IR: TMS 1,1,0,0.
  - SHIFT: len TCK cycles. Cycle i drives TDI=data[i] and captures TDO into rsp_data[i]. TMS=0 on every cycle except the last, where TMS=1 (Exit1).
  - POST: TMS 1,0 (Update, Run-Test/Idle). TDI=0.
  - TRST_SEQ: same TMS sequence as INIT_RST; rsp_data=0.
  - RSP: rsp_valid=1, outputs stable, cmd_ready=0 until rsp_ready. Then go to IDLE; cmd_ready is asserted on the next clock.
- Scan length in TCK cycles: DR = len+5, IR = len+6, TAP reset = 6.
- TDO sampled with jtag_TDO_driven=0 captures a 0 and sets rsp_undriven (sticky per command).
- A new cmd_valid is ignored unless cmd_ready=1. At most one command is in flight; there is no queuing.
- Reset asserted mid-operation aborts immediately to reset values. The aborted response is lost, and INIT_RST runs again after release.

Decomposition:
- Package jtag_seq_pkg holds:
  - state enum (INIT_RST, IDLE, PRE_DR, PRE_IR, SHIFT, POST, TRST_SEQ, RSP)
  - cmd_op encodings
  - TMS prefix constants: PRE_DR=3'b001 and PRE_IR=4'b0011, both LSB-first
  - TAP reset TMS sequence 6'b011111
- Sub-module jtag_tck_gen: CLK_DIV counter with enable input; outputs tck_rise and tck_fall strobes and the TCK level.

Test Plan:
1. Release reset (CLK_DIV=2) -> jtag_TRSTn=1 one clock later; 6 TCK pulses with TMS 1,1,1,1,1,0; cmd_ready=1; rsp_valid stays 0.
2. DR scan, len=8, data=0xA5, bench TAP in BYPASS (1-bit register, captures 0) -> 13 TCK pulses; TDI in shift = 1,0,1,0,0,1,0,1; rsp_data=0x4A; rsp_undriven=0.
3. IR scan, len=5, data=0x01 -> 11 TCK pulses with TMS 1,1,0,0,0,0,0,0,1,1,0; TDI=1 on the first shift cycle only; TCK high/low each 2 clocks.
4. DR scan, len=0 then len=100, with jtag_TDO_driven=0 -> shifts 1 and 64 bits respectively; rsp_data=0; rsp_undriven=1.
5. Hold rsp_ready=0 for 20 clocks while pulsing cmd_valid -> rsp_valid, rsp_data stable; cmd_ready=0; TCK static; no command accepted; accept occurs the clock after rsp_ready.
6. Assert reset during SHIFT bit 3 of a 32-bit DR scan -> outputs take reset values without waiting for a clock edge; after release INIT_RST replays; no response for the aborted scan.
